measure_centroid: RTL

Parametrised successor to the single-object position measurement block: accumulates qualifying motion pixels over a frame and reports centroid (x,y), bounding box, pixel count and an object-found flag once per frame. Thresholding is configurable rather than all-ones. The per-pixel divide is replaced by a multi-cycle sequential divider. It sits after the frame-difference stage and feeds the tracker/overlay logic with a one-cycle `result_valid` pulse.

---
 rtl/measure_pkg.sv | 16 +
 rtl/seq_divider.sv | 64 ++++++
 rtl/measure_centroid.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/measure_pkg.sv
// Shared width helpers and FSM state encoding for the centroid measurement block.
package measure_pkg;

  typedef enum logic [1:0] {StIdle, StDivide, StPublish} state_t;

  // Counter width: enough to hold every pixel of a full frame.
  function automatic int unsigned cnt_w_of(input int unsigned x_max, input int unsigned y_max);
    return $clog2(x_max * y_max + 1);
  endfunction

  function automatic int unsigned sum_w_of(input int unsigned x_max, input int unsigned y_max,
                                           input int unsigned in_w);
    return cnt_w_of(x_max, y_max) + in_w;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, SUM_W cycles per divide.
module seq_divider #(
  parameter int unsigned SUM_W = 30,
  parameter int unsigned CNT_W = 19
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic             abort,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int unsigned STEP_W = $clog2(SUM_W + 1);

  logic [SUM_W-1:0]  quot_q;
  logic [CNT_W:0]    rem_q;
  logic [CNT_W-1:0]  dvs_q;
  logic [STEP_W-1:0] steps_q;
  logic              run_q;
  logic [CNT_W:0]    rem_sh;
  logic [CNT_W:0]    rem_nx;
  logic              fits;

  always_comb begin
    rem_sh = {rem_q[CNT_W-1:0], quot_q[SUM_W-1]};
    fits   = rem_sh >= {1'b0, dvs_q};
    rem_nx = fits ? rem_sh - {1'b0, dvs_q} : rem_sh;
  end

  // High in the cycle whose closing edge produces the final quotient bit.
  assign done     = run_q && (steps_q == STEP_W'(1));
  assign quotient = quot_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      steps_q <= '0;
      run_q   <= 1'b0;
    end else if (abort) begin
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      steps_q <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      quot_q  <= dividend;
      rem_q   <= '0;
      dvs_q   <= divisor;
      steps_q <= STEP_W'(SUM_W);
      run_q   <= 1'b1;
    end else if (run_q) begin
      quot_q  <= {quot_q[SUM_W-2:0], fits};
      rem_q   <= rem_nx;
      steps_q <= steps_q - STEP_W'(1);
      if (steps_q == STEP_W'(1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/measure_centroid.sv
// Per-frame motion centroid, bounding box and pixel count with a shared multi-cycle divide.
module measure_centroid
  import measure_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 11,
  parameter int unsigned COLOR_WIDTH = 10,
  parameter int unsigned FRAME_X_MAX = 640,
  parameter int unsigned FRAME_Y_MAX = 480,
  parameter int unsigned MIN_COUNT   = 16,
  localparam int unsigned CNT_W = cnt_w_of(FRAME_X_MAX, FRAME_Y_MAX),
  localparam int unsigned SUM_W = sum_w_of(FRAME_X_MAX, FRAME_Y_MAX, INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   enable,
  input  logic [INPUT_WIDTH-1:0] vga_x,
  input  logic [INPUT_WIDTH-1:0] vga_y,
  input  logic [COLOR_WIDTH-1:0] delta_frame,
  input  logic [COLOR_WIDTH-1:0] threshold,
  output logic [INPUT_WIDTH-1:0] x_position,
  output logic [INPUT_WIDTH-1:0] y_position,
  output logic [INPUT_WIDTH-1:0] x_min,
  output logic [INPUT_WIDTH-1:0] x_max,
  output logic [INPUT_WIDTH-1:0] y_min,
  output logic [INPUT_WIDTH-1:0] y_max,
  output logic [CNT_W-1:0]       pixel_count,
  output logic                   object_found,
  output logic                   result_valid,
  output logic                   busy,
  output logic                   overrun
);

  logic                   qual, eof, snap_found;
  logic [CNT_W-1:0]       cnt_q, cnt_nx, snap_cnt_q;
  logic [SUM_W-1:0]       sx_q, sy_q, sx_nx, sy_nx, quot_x, quot_y;
  logic [INPUT_WIDTH-1:0] xlo_q, xhi_q, ylo_q, yhi_q, xlo_nx, xhi_nx, ylo_nx, yhi_nx;
  logic [INPUT_WIDTH-1:0] snap_xlo_q, snap_xhi_q, snap_ylo_q, snap_yhi_q;
  logic                   snap_found_q, div_start, div_abort, done_x, done_y;
  state_t                 state_q;

  assign qual = delta_frame >= threshold;
  assign eof  = (vga_x == INPUT_WIDTH'(FRAME_X_MAX)) && (vga_y == INPUT_WIDTH'(FRAME_Y_MAX));

  // Running totals including the current pixel; this is also the EOF snapshot.
  always_comb begin
    cnt_nx     = cnt_q + CNT_W'(qual);
    sx_nx      = qual ? sx_q + SUM_W'(vga_x) : sx_q;
    sy_nx      = qual ? sy_q + SUM_W'(vga_y) : sy_q;
    xlo_nx     = (qual && vga_x < xlo_q) ? vga_x : xlo_q;
    xhi_nx     = (qual && vga_x > xhi_q) ? vga_x : xhi_q;
    ylo_nx     = (qual && vga_y < ylo_q) ? vga_y : ylo_q;
    yhi_nx     = (qual && vga_y > yhi_q) ? vga_y : yhi_q;
    snap_found = cnt_nx >= CNT_W'(MIN_COUNT);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset || !enable || eof) begin
      cnt_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      xlo_q <= '1;
      xhi_q <= '0;
      ylo_q <= '1;
      yhi_q <= '0;
    end else begin
      cnt_q <= cnt_nx;
      sx_q  <= sx_nx;
      sy_q  <= sy_nx;
      xlo_q <= xlo_nx;
      xhi_q <= xhi_nx;
      ylo_q <= ylo_nx;
      yhi_q <= yhi_nx;
    end
  end

  assign div_start = enable && eof && snap_found;
  assign div_abort = !enable || (eof && !snap_found);

  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_x (
    .clk(clk), .areset(areset), .start(div_start), .abort(div_abort),
    .dividend(sx_nx), .divisor(cnt_nx), .done(done_x), .quotient(quot_x)
  );

  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_y (
    .clk(clk), .areset(areset), .start(div_start), .abort(div_abort),
    .dividend(sy_nx), .divisor(cnt_nx), .done(done_y), .quotient(quot_y)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset || !enable) begin
      state_q      <= StIdle;
      snap_cnt_q   <= '0;
      snap_found_q <= 1'b0;
      snap_xlo_q   <= '0;
      snap_xhi_q   <= '0;
      snap_ylo_q   <= '0;
      snap_yhi_q   <= '0;
      x_position   <= '0;
      y_position   <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      pixel_count  <= '0;
      object_found <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      unique case (state_q)
        StIdle: ;
        StDivide: begin
          if (done_x && done_y) begin
            state_q <= StPublish;
            busy    <= 1'b0;
          end
        end
        StPublish: begin
          result_valid <= 1'b1;
          pixel_count  <= snap_cnt_q;
          object_found <= snap_found_q;
          if (snap_found_q) begin
            x_position <= quot_x[INPUT_WIDTH-1:0];
            y_position <= quot_y[INPUT_WIDTH-1:0];
            x_min      <= snap_xlo_q;
            x_max      <= snap_xhi_q;
            y_min      <= snap_ylo_q;
            y_max      <= snap_yhi_q;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // A new frame end always wins: any divide in flight is discarded and restarted.
      if (eof) begin
        snap_cnt_q   <= cnt_nx;
        snap_found_q <= snap_found;
        snap_xlo_q   <= xlo_nx;
        snap_xhi_q   <= xhi_nx;
        snap_ylo_q   <= ylo_nx;
        snap_yhi_q   <= yhi_nx;
        overrun      <= (state_q == StDivide);
        state_q      <= snap_found ? StDivide : StPublish;
        busy         <= snap_found;
      end
    end
  end

endmodule
